// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_SRC AXI-stream sources share one
// registered output; a granted packet holds the datapath until its tlast beat.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | no packet in flight; arbitrate among valid sources every cycle
// LOCKED | mid-packet; only grant_idx may be accepted until its tlast beat
module axis_pkt_rr_arbiter #(
    parameter  int NUM_SRC = 4,
    parameter  int WIDTH   = 512,
    localparam int IDX_W   = $clog2(NUM_SRC),
    localparam int KEEP_W  = WIDTH / 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NUM_SRC-1:0]          s_axis_tvalid,
    output logic [NUM_SRC-1:0]          s_axis_tready,
    input  logic [NUM_SRC*WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_SRC*KEEP_W-1:0]   s_axis_tkeep,
    input  logic [NUM_SRC-1:0]          s_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_W-1:0]           m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic [IDX_W-1:0]            m_axis_tdest
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  next_ptr;
    logic              any_valid;
    logic              load;
    logic              accept;

    logic [WIDTH-1:0]  src_data [NUM_SRC];
    logic [KEEP_W-1:0] src_keep [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slice
        assign src_data[g] = s_axis_tdata[g*WIDTH +: WIDTH];
        assign src_keep[g] = s_axis_tkeep[g*KEEP_W +: KEEP_W];
    end

    // Walk from the highest offset down so the source nearest rr_ptr wins.
    always_comb begin
        int                idx;
        logic [IDX_W-1:0]  cand;
        grant     = rr_ptr;
        any_valid = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = k + int'(rr_ptr);
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            cand = IDX_W'(idx);
            if (s_axis_tvalid[cand]) begin
                grant     = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign load     = !m_axis_tvalid || m_axis_tready;
    assign sel      = (state == LOCKED) ? grant_idx : grant;
    assign next_ptr = (grant == IDX_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;

    // Ready is forced low while reset is asserted, even though the output
    // register reads as empty then.
    always_comb begin
        s_axis_tready = '0;
        if (aresetn && load && (state == LOCKED || any_valid))
            s_axis_tready[sel] = 1'b1;
    end

    assign accept = s_axis_tvalid[sel] && s_axis_tready[sel];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_idx     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdest  <= '0;
        end else begin
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= src_data[sel];
                m_axis_tkeep  <= src_keep[sel];
                m_axis_tlast  <= s_axis_tlast[sel];
                m_axis_tdest  <= sel;
                case (state)
                    IDLE: begin
                        grant_idx <= grant;
                        rr_ptr    <= next_ptr;
                        state     <= s_axis_tlast[sel] ? IDLE : LOCKED;
                    end
                    LOCKED: begin
                        if (s_axis_tlast[sel]) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (load) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
